ad_frame_capture: RTL and testbench
===================================

# ad_frame_capture

Upstream stage of the IFFT/FFT processing chain. Captures one frame of 10-bit unsigned ADC samples on `fft_clk` into an internal frame buffer, converts each sample to signed, scaled, complex form, and streams the frame to the FFT core over an AXI4-Stream master interface with full back-pressure support. It replaces free-running `ad_data` feeding with a framed, gap-tolerant, `tlast`-delimited stream.

## Interface
- `DATA_W`, 10: ADC sample width.
- `FRAME_LEN`, 1024: samples per frame; power of two, 8..4096.
- `SHIFT`, 5: left shift applied after offset removal; `DATA_W+SHIFT` ≤ 16.
- `fft_clk`  in  1: sole clock; all logic on its rising edge.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `ad_data`  in  DATA_W: unsigned offset-binary ADC sample, valid every cycle.
- `start`  in  1: level-sampled; arms capture of one frame when in IDLE.
- `cont_en`  in  1: 1 = re-arm automatically after each frame.
- `m_axis_tdata`  out  32: `{imag[15:0]=0, real[15:0]}`.
- `m_axis_tvalid`  out  1: AXIS valid.
- `m_axis_tready`  in  1: AXIS ready from FFT core.
- `m_axis_tlast`  out  1: high on sample `FRAME_LEN-1`.
- `busy`  out  1: high in CAPTURE or STREAM.
- `frame_done`  out  1: one-cycle pulse after the final handshake.
- `frame_cnt`  out  16: completed frames, wraps 0xFFFF→0.

## Operation
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `busy`, and `frame_done` = 0; `m_axis_tdata` = 0; `frame_cnt` = 0; state = IDLE; counters = 0.
- FSM states:
  - IDLE: if `start` = 1 at an edge, go to CAPTURE.
  - CAPTURE: write `ad_data` to `buf[wr_cnt]` each cycle. After write `FRAME_LEN-1`, go to STREAM.
  - STREAM: read `buf[rd_cnt]` and present it on AXIS. On the handshake carrying `tlast`, pulse `frame_done`, increment `frame_cnt`, then go to CAPTURE if `cont_en` = 1, else IDLE.
- Conversion: `s = ad_data - 2^(DATA_W-1)` as signed DATA_W; `real = sign_extend16(s) << SHIFT`.
  - Examples (default parameters): 0 → 0xC000; 512 → 0x0000; 1023 → 0x3FE0.
- Imaginary half of `tdata` is always 0.
- `ad_data` is ignored outside CAPTURE. Samples arriving during STREAM are dropped by design (single buffer).
- `start` in CAPTURE or STREAM has no effect. `cont_en` is sampled only at the final handshake.
- AXIS rules:
  - `tdata` and `tlast` are held stable while `tvalid && !tready`.
  - `tvalid` is never withdrawn before the handshake.
  - Exactly FRAME_LEN beats per frame.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded with no `tlast` and no `frame_done`.

## Timing
- Sample 0 is the `ad_data` value at the first rising edge with state = CAPTURE, i.e. the edge after the one that sampled `start`.
- Capture occupies exactly FRAME_LEN cycles.
- `m_axis_tvalid` rises at most 2 cycles after entering STREAM (1-cycle RAM read plus output register).
- With `tready` held at 1, beats are back-to-back: one per cycle and no bubbles after the first.
- Back-pressure: a 2-entry skid on the read path keeps full throughput when `tready` toggles every cycle.
- `frame_done` is asserted the cycle after the `tlast` handshake. The same cycle is the first CAPTURE cycle in continuous mode.
- `busy` falls in the cycle state returns to IDLE.

## Structure
- Shared package `adc_pkg`:
  - `ADC_MID` midscale constant.
  - AXIS data width (32).
  - state enum `{IDLE, CAPTURE, STREAM}`.
  - conversion function `adc_to_q15`.
- Sub-module `frame_ram`: simple dual-port, 1 write / 1 read port, registered read (1-cycle latency), depth FRAME_LEN, width 16. It stores already-converted samples.
- Top level contains the FSM, counters, and the AXIS output/skid register.

## Test plan
- Ramp, default flow (FRAME_LEN=8, SHIFT=5): `ad_data` = 0..7 during capture, `tready`=1 → 8 consecutive beats with `real` = 0xC000, 0xC020 … 0xC0E0; `tlast` on beat 8 only; one `frame_done`; `frame_cnt`=1.
- Back-pressure: same frame with `tready` pattern 1,0,0,1,0,1… → `tdata` held during stalls; 8 beats in order; no duplicates or losses.
- Continuous mode: `cont_en`=1, 3 frames → `frame_cnt`=3; `busy` stays 1 throughout; sample 0 of frame 2 = `ad_data` on the cycle after `frame_done`.
- Ignored start: `start` pulsed during STREAM → no extra frame; return to IDLE after `tlast`.
- Extremes: `ad_data`=0, 512, 1023 → `real` = 0xC000, 0x0000, 0x3FE0; imaginary half always 0.
- Reset mid-stream: `sys_rst_n` low after beat 3 → `tvalid`=0 at once; `frame_cnt`=0; next `start` yields a full clean 8-beat frame.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame capture front end.
// Holds the FSM encoding, stream width and sample conversion.
package adc_pkg;

    localparam int AXIS_W  = 32;
    localparam int ADC_MID = 512;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STREAM
    } state_t;

    // Offset-binary to signed, then scale; 16-bit wrap gives sign extension.
    function automatic logic [15:0] adc_to_q15(
        input logic [15:0] raw,
        input int          data_w,
        input int          shift
    );
        logic [15:0] mid;
        logic [15:0] s;
        mid = 16'd1 << (data_w - 1);
        s   = raw - mid;
        return s << shift;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer, one write and one read port.
// Read data is registered, so it appears one cycle after rd_en.
module frame_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ad_frame_capture.sv
// Captures one ADC frame into a buffer and streams it over AXIS.
// Read path is RAM -> output register + one skid entry.
module ad_frame_capture
    import adc_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int FRAME_LEN = 1024,
    parameter int SHIFT     = 5
) (
    input  logic              fft_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              start,
    input  logic              cont_en,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          rd_all;
    logic          rd_en;
    logic          rd_pend;
    logic          rd_pend_last;
    logic [15:0]   ram_rdata;
    logic [15:0]   wr_data;
    logic          skid_valid;
    logic          skid_last;
    logic [15:0]   skid_data;
    logic          pop;
    logic          fin;
    logic [1:0]    occ;

    assign wr_data = adc_to_q15(16'(ad_data), DATA_W, SHIFT);
    assign pop     = m_axis_tvalid & m_axis_tready;
    assign fin     = pop & m_axis_tlast;

    frame_ram #(
        .DEPTH (FRAME_LEN),
        .AW    (AW)
    ) u_ram (
        .clk     (fft_clk),
        .wr_en   (state == CAPTURE),
        .wr_addr (wr_cnt),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt),
        .rd_data (ram_rdata)
    );

    // Issue a read only when the output stage will have room for it
    always_comb begin
        occ   = {1'b0, m_axis_tvalid} + {1'b0, skid_valid}
              + {1'b0, rd_pend};
        rd_en = (state == STREAM) && !rd_all
              && ((occ - {1'b0, pop}) < 2'd2);
    end

    // Frame FSM, counters and status outputs
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_all     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CAPTURE;
                        busy   <= 1'b1;
                        wr_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt == LAST) begin
                        state  <= STREAM;
                        rd_cnt <= '0;
                        rd_all <= 1'b0;
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST) rd_all <= 1'b1;
                    end
                    if (fin) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        if (cont_en) begin
                            state  <= CAPTURE;
                            wr_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register with one skid entry behind it
    always_ff @(posedge fft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_pend       <= 1'b0;
            rd_pend_last  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
            skid_data     <= '0;
        end else begin
            rd_pend      <= rd_en;
            rd_pend_last <= rd_en && (rd_cnt == LAST);
            if (!m_axis_tvalid) begin
                if (rd_pend) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= rd_pend_last;
                    m_axis_tdata  <= {16'h0, ram_rdata};
                end
            end else if (pop) begin
                if (skid_valid) begin
                    m_axis_tlast <= skid_last;
                    m_axis_tdata <= {16'h0, skid_data};
                    skid_valid   <= rd_pend;
                    skid_last    <= rd_pend_last;
                    skid_data    <= ram_rdata;
                end else if (rd_pend) begin
                    m_axis_tlast <= rd_pend_last;
                    m_axis_tdata <= {16'h0, ram_rdata};
                end else begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_last  <= rd_pend_last;
                skid_data  <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ad_frame_capture.sv
// Scoreboard bench for ad_frame_capture with FRAME_LEN = 8.
// Stimulus pushes expected beats; a monitor pops and compares.
module tb_ad_frame_capture;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ad_data = '0;
    logic        start = 1'b0;
    logic        cont_en = 1'b0;
    logic        tready = 1'b1;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    ad_frame_capture #(
        .DATA_W    (10),
        .FRAME_LEN (FL),
        .SHIFT     (5)
    ) dut (
        .fft_clk       (clk),
        .sys_rst_n     (rst_n),
        .ad_data       (ad_data),
        .start         (start),
        .cont_en       (cont_en),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    int          beats = 0;
    int          done_seen = 0;
    int          exp_frames = 0;
    int          tmode = 0;
    int          tcnt = 0;
    bit          busy_watch = 0;
    int          busy_drops = 0;
    logic [9:0]  smp [FL];
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};

    // Reference: offset removal and scaling in plain integer arithmetic
    function automatic logic [32:0] ref_word(input logic [9:0] s, input bit last);
        int v;
        logic [15:0] r;
        v = (int'(s) - 512) * 32;
        r = v[15:0];
        return {last, 16'h0000, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tready generator: always-on, fixed pattern, or random
    always @(negedge clk) begin
        case (tmode)
            0: tready = 1'b1;
            1: begin
                tready = pat[tcnt % 6];
                tcnt++;
            end
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard compare, hold-stability and gap checks
    initial begin
        bit          hold_pend;
        logic [31:0] hold_data;
        logic        hold_last;
        bit          first;
        int          cyc;
        int          last_cyc;
        logic [32:0] e;
        hold_pend = 0;
        first = 1;
        cyc = 0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                hold_pend = 0;
                first = 1;
            end else begin
                if (hold_pend) begin
                    vectors++;
                    if (!(tvalid && tdata == hold_data && tlast == hold_last)) begin
                        errors++;
                        $display("FAIL hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                                 tvalid, tdata, tlast, hold_data, hold_last);
                    end
                end
                if (frame_done) done_seen++;
                if (tvalid && tready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: got %0h last=%0b expected no beat", tdata, tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if ({tlast, tdata} !== e) begin
                            errors++;
                            $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                                     tlast, tdata, e[32], e[31:0]);
                        end
                    end
                    if (tmode == 0 && !first) begin
                        vectors++;
                        if (cyc - last_cyc != 1) begin
                            errors++;
                            $display("FAIL gap: got %0d cycles expected 1", cyc - last_cyc);
                        end
                    end
                    beats++;
                    last_cyc = cyc;
                    first = tlast;
                end
                hold_pend = tvalid && !tready;
                hold_data = tdata;
                hold_last = tlast;
            end
        end
    end

    // Drive one frame; caller is at the negedge before sample 0's edge
    task automatic capture_frame();
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            ad_data = smp[i];
            exp_q.push_back(ref_word(smp[i], i == FL - 1));
            if (busy_watch && !busy) busy_drops++;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        ad_data = 10'($urandom);
        @(negedge clk);
        start = 1'b0;
        capture_frame();
    endtask

    task automatic fill_random();
        for (int i = 0; i < FL; i++) smp[i] = 10'($urandom);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < FL; i++) smp[i] = 10'(i);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ad_data = 10'($urandom);
            if (!busy) return;
        end
        errors++;
        $display("FAIL %s timeout: got busy=1 expected busy=0", name);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) return;
            ad_data = 10'($urandom);
            if (busy_watch && !busy) busy_drops++;
        end
        errors++;
        $display("FAIL %s timeout: got frame_done=0 expected 1", name);
    endtask

    task automatic end_checks(input string name, input int nframes);
        exp_frames += nframes;
        @(negedge clk);
        #3;
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({name, "_done_cnt"}, 32'(done_seen), 32'(exp_frames));
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int b0;
        bit hit;
        #2;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tmode = 0;
        fill_ramp();
        start_frame();
        wait_idle("ramp");
        end_checks("ramp", 1);

        tmode = 1;
        tcnt = 0;
        fill_random();
        start_frame();
        wait_idle("bp");
        end_checks("bp", 1);

        tmode = 2;
        smp = '{10'd0, 10'd512, 10'd1023, 10'd1, 10'd511, 10'd513, 10'd1022, 10'd0};
        start_frame();
        wait_idle("ext");
        end_checks("ext", 1);

        tmode = 2;
        cont_en = 1'b1;
        busy_watch = 1;
        busy_drops = 0;
        fill_random();
        start_frame();
        wait_done("cont1");
        fill_random();
        capture_frame();
        wait_done("cont2");
        cont_en = 1'b0;
        fill_random();
        capture_frame();
        wait_done("cont3");
        busy_watch = 0;
        check("cont_busy_drops", 32'(busy_drops), 32'd0);
        wait_idle("cont");
        end_checks("cont", 3);

        tmode = 1;
        tcnt = 0;
        fill_random();
        start_frame();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (tvalid) hit = 1;
        end
        check("ign_stream_seen", 32'(hit), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ign");
        end_checks("ign", 1);
        repeat (20) @(negedge clk);
        check("ign_no_rearm", 32'(busy), 32'd0);
        check("ign_cnt_hold", 32'(frame_cnt), 32'(exp_frames));

        for (int k = 0; k < 4; k++) begin
            tmode = k % 3;
            tcnt = 0;
            fill_random();
            start_frame();
            wait_idle("rnd");
            end_checks("rnd", 1);
        end

        tmode = 0;
        fill_ramp();
        b0 = beats;
        start_frame();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #3;
            if (beats >= b0 + 3) hit = 1;
        end
        check("rstm_beats", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstm_tvalid", 32'(tvalid), 32'd0);
        check("rstm_tlast", 32'(tlast), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_cnt", 32'(frame_cnt), 32'd0);
        check("rstm_tdata", tdata, 32'd0);
        exp_q.delete();
        exp_frames = 0;
        done_seen = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        start_frame();
        wait_idle("post_rst");
        end_checks("post_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
